z80_bus_snoop: RTL and testbench
================================

Z80_BUS_SNOOP -- requirements
Module: z80_bus_snoop

Interface
REQ-001 Parameter PHASE, default 4: cycles each multiplexed lane enable is held; lane is sampled on its last cycle; legal range 2..15.
REQ-002 Parameter WE_LEN, default 5: length in cycles of the video-RAM write pulse; legal range 1..15.
REQ-003 clk  input  1  master clock, 100 MHz.
REQ-004 rst_neg  input  1  reset, asynchronous, active-low.
REQ-005 in_mreq  input  1  Z80 MREQ, active-low, asynchronous to clk.
REQ-006 in_iorq  input  1  Z80 IORQ, active-low, asynchronous to clk.
REQ-007 in_wr  input  1  Z80 WR, active-low, asynchronous to clk.
REQ-008 lin  input  8  shared lane bus carrying A[7:0], A[15:8] or D[7:0], selected by the enables.
REQ-009 o_en_al, o_en_ah, o_en_d  output  1 each  active-low lane enables for A-low, A-high and data buffers.
REQ-010 o_we  output  1  video-RAM write strobe, active-high.
REQ-011 o_addr  output  13  video-RAM address, captured A[12:0].
REQ-012 o_data  output  8  video-RAM write data.
REQ-013 o_border  output  3  border colour latched from ULA port writes.
REQ-014 o_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 in_mreq, in_iorq and in_wr SHALL each pass a 2-flop synchronizer; lin SHALL be registered once. All decisions SHALL use only the synchronized or registered copies.
REQ-016 "Strobe" is asserted when synchronized mreq or iorq is low. When both are low, the cycle SHALL be classed as a memory cycle (mreq priority).
REQ-017 FSM states: IDLE, LANE_AL, LANE_AH, LANE_D, DECIDE, WRITE, WAIT_END.
REQ-018 IDLE -> LANE_AL on the first cycle the strobe is seen. The cycle class (mem/io) SHALL be latched at that point.
REQ-019 Each LANE_x state SHALL last exactly PHASE cycles with only its own enable low. On its last cycle, the registered lin SHALL be captured into the A-low, A-high or data register. The next enable SHALL go low in the cycle after the previous one goes high, so enables never overlap.
REQ-020 With PHASE=4, the lane enables SHALL be low on cycles 1-4, 5-8 and 9-12 after strobe detection; all enables SHALL be high from DECIDE onward.
REQ-021 In DECIDE the FSM SHALL wait until synchronized wr is low, then take exactly one of these transitions:
- Memory cycle with address in 0x4000..0x5AFF inclusive -> WRITE.
- I/O cycle with A[0]=0 -> latch o_border<=D[2:0] in that cycle, then go to WAIT_END.
- Any other cycle -> WAIT_END with no side effects.
REQ-022 If the strobe deasserts while waiting in DECIDE (a read cycle), the FSM SHALL go to IDLE with no write.
REQ-023 o_addr and o_data SHALL update only on entry to WRITE, and SHALL hold until the next WRITE entry.
REQ-024 WRITE SHALL drive o_we high for exactly WE_LEN consecutive cycles, then go to WAIT_END. o_we SHALL be high at no other time.
REQ-025 WAIT_END SHALL go to IDLE on the first cycle the strobe is deasserted. Exactly one decode SHALL occur per bus cycle, however long the strobe stays low.
REQ-026 Abort: if the strobe deasserts in any LANE_x or WRITE state, all enables SHALL go high and o_we SHALL go low in the next cycle, then the FSM SHALL go to IDLE. Partially captured registers SHALL be discarded. An aborted WRITE SHALL NOT be restarted.
REQ-027 Addresses 0x3FFF and 0x5B00 SHALL produce no write; 0x4000 SHALL map to o_addr 0x0000 and 0x5AFF to 0x1AFF.
REQ-028 o_busy SHALL be combinational from the state, and low only in IDLE.

Reset
REQ-029 While rst_neg is low, outputs SHALL be:
- o_en_al=o_en_ah=o_en_d=1 and o_we=0.
- o_addr=0, o_data=0 and o_border=3'd7.
- FSM in IDLE and synchronizers at 1 (inactive).
REQ-030 An asynchronous reset mid-cycle SHALL abort immediately with no write. After release, a strobe still held low SHALL be treated as a new cycle only once synchronized; it SHALL be captured as a fresh cycle.

Verification
REQ-031 Memory write 0x4123<-0xA5, strobe held 40 cycles -> enable windows at 1-4, 5-8 and 9-12; one 5-cycle o_we pulse with o_addr=0x0123 and o_data=0xA5.
REQ-032 Memory writes to 0x3FFF and to 0x5B00, then to 0x5AFF<-0x3C -> no o_we for the first two; one pulse at o_addr=0x1AFF with o_data=0x3C.
REQ-033 Memory read at 0x4000 (wr high throughout) -> no o_we; o_busy falls 1 cycle after synchronized mreq rises.
REQ-034 I/O write to port 0x00FE with data 0x02, then to port 0x00FF with data 0x05 -> o_border=2 after the first; unchanged after the second; o_we never high.
REQ-035 Strobe released during LANE_AH, then a valid write at 0x4800<-0x11 -> no write for the first cycle; the second writes o_addr=0x0800 with o_data=0x11.
REQ-036 rst_neg pulsed low during WRITE -> o_we falls asynchronously; o_border returns to 7; enables go high; no further o_we until a new bus cycle.

Source files
------------

// File: rtl/z80_bus_snoop.sv
// Z80 bus snooper: samples the multiplexed address/data lanes of each bus cycle
// and mirrors writes in the video-RAM window and ULA border writes.
module z80_bus_snoop #(
  parameter int PHASE  = 4,
  parameter int WE_LEN = 5
) (
  input  logic        clk,
  input  logic        rst_neg,
  input  logic        in_mreq,
  input  logic        in_iorq,
  input  logic        in_wr,
  input  logic [7:0]  lin,
  output logic        o_en_al,
  output logic        o_en_ah,
  output logic        o_en_d,
  output logic        o_we,
  output logic [12:0] o_addr,
  output logic [7:0]  o_data,
  output logic [2:0]  o_border,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE, LANE_AL, LANE_AH, LANE_D, DECIDE, WRITE, WAIT_END
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  mreq_sync, iorq_sync, wr_sync;
  logic [7:0]  lin_q, a_lo, a_hi, d_q;
  logic        mem_cycle;
  logic [3:0]  cnt;
  logic        strobe, wr_act, lane_last, we_last, addr_hit, border_hit;
  logic        take_write, take_border;

  assign strobe     = ~mreq_sync[1] | ~iorq_sync[1];
  assign wr_act     = ~wr_sync[1];
  assign lane_last  = (cnt == 4'(PHASE - 1));
  assign we_last    = (cnt == 4'(WE_LEN - 1));
  assign addr_hit   = ({a_hi, a_lo} >= 16'h4000) && ({a_hi, a_lo} <= 16'h5AFF);
  assign border_hit = ~mem_cycle & ~a_lo[0];

  // Bus strobes idle high, so the synchronizers reset to the inactive level.
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      mreq_sync <= 2'b11;
      iorq_sync <= 2'b11;
      wr_sync   <= 2'b11;
      lin_q     <= 8'h00;
    end else begin
      mreq_sync <= {mreq_sync[0], in_mreq};
      iorq_sync <= {iorq_sync[0], in_iorq};
      wr_sync   <= {wr_sync[0], in_wr};
      lin_q     <= lin;
    end
  end

  // One counter times both the lane windows and the write pulse; it restarts on every state change.
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 4'd0 : cnt + 4'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    take_write  = 1'b0;
    take_border = 1'b0;
    case (state)
      IDLE:     if (strobe) state_nxt = LANE_AL;
      LANE_AL:  if (!strobe) state_nxt = IDLE; else if (lane_last) state_nxt = LANE_AH;
      LANE_AH:  if (!strobe) state_nxt = IDLE; else if (lane_last) state_nxt = LANE_D;
      LANE_D:   if (!strobe) state_nxt = IDLE; else if (lane_last) state_nxt = DECIDE;
      DECIDE: begin
        if (!strobe) begin
          state_nxt = IDLE;
        end else if (wr_act) begin
          if (mem_cycle && addr_hit) begin
            state_nxt  = WRITE;
            take_write = 1'b1;
          end else begin
            state_nxt   = WAIT_END;
            take_border = border_hit;
          end
        end
      end
      WRITE:    if (!strobe) state_nxt = IDLE; else if (we_last) state_nxt = WAIT_END;
      WAIT_END: if (!strobe) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Lane captures happen on the last cycle of each window, when lin_q has settled.
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      mem_cycle <= 1'b0;
      a_lo      <= 8'h00;
      a_hi      <= 8'h00;
      d_q       <= 8'h00;
      o_addr    <= 13'h0000;
      o_data    <= 8'h00;
      o_border  <= 3'd7;
    end else begin
      if (state == IDLE && strobe) mem_cycle <= ~mreq_sync[1];
      if (state == LANE_AL && lane_last) a_lo <= lin_q;
      if (state == LANE_AH && lane_last) a_hi <= lin_q;
      if (state == LANE_D && lane_last) d_q <= lin_q;
      if (take_write) begin
        o_addr <= {a_hi[4:0], a_lo};
        o_data <= d_q;
      end
      if (take_border) o_border <= d_q[2:0];
    end
  end

  assign o_en_al = (state != LANE_AL);
  assign o_en_ah = (state != LANE_AH);
  assign o_en_d  = (state != LANE_D);
  assign o_we    = (state == WRITE);
  assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_z80_bus_snoop.sv
// Self-checking bench for z80_bus_snoop: fixed vectors, hand-written corner
// sequences and randomized bus cycles checked against a cycle-level model.
module tb_z80_bus_snoop;

  localparam int PHASE  = 4;
  localparam int WE_LEN = 5;

  logic        clk = 1'b0;
  logic        rst_neg = 1'b0;
  logic        in_mreq = 1'b1, in_iorq = 1'b1, in_wr = 1'b1;
  logic [7:0]  lin;
  logic        o_en_al, o_en_ah, o_en_d, o_we, o_busy;
  logic [12:0] o_addr;
  logic [7:0]  o_data;
  logic [2:0]  o_border;

  logic [15:0] bus_addr = 16'h0000;
  logic [7:0]  bus_data = 8'h00;

  int checks = 0, failures = 0;
  int pulse_count = 0, cur_len = 0, last_len = 0, inv_err = 0;
  logic [2:0] en_hist [64];

  logic [12:0] mdl_addr;
  logic [7:0]  mdl_data;
  logic [2:0]  mdl_border;

  typedef struct {
    int          cls;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        wr;
    int          pulses;
    logic [12:0] e_addr;
    logic [7:0]  e_data;
    logic [2:0]  e_border;
  } vec_t;
  vec_t vecs [10];

  z80_bus_snoop #(.PHASE(PHASE), .WE_LEN(WE_LEN)) dut (
    .clk(clk), .rst_neg(rst_neg), .in_mreq(in_mreq), .in_iorq(in_iorq),
    .in_wr(in_wr), .lin(lin), .o_en_al(o_en_al), .o_en_ah(o_en_ah),
    .o_en_d(o_en_d), .o_we(o_we), .o_addr(o_addr), .o_data(o_data),
    .o_border(o_border), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // External lane buffers: whichever enable is low puts its byte on the shared bus.
  assign lin = !o_en_al ? bus_addr[7:0] : !o_en_ah ? bus_addr[15:8] : !o_en_d ? bus_data : 8'hFF;

  always @(negedge clk) begin
    if (o_we) begin
      cur_len++;
    end else if (cur_len != 0) begin
      pulse_count++;
      last_len = cur_len;
      cur_len = 0;
    end
    if (int'(!o_en_al) + int'(!o_en_ah) + int'(!o_en_d) > 1) inv_err++;
    if (o_we && !(o_en_al && o_en_ah && o_en_d)) inv_err++;
    if ((o_we || !o_en_al || !o_en_ah || !o_en_d) && !o_busy) inv_err++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clearMon();
    @(negedge clk);
    #1;
    pulse_count = 0;
    cur_len = 0;
    last_len = 0;
  endtask

  task automatic driveBus(input int cls, input logic [15:0] a, input logic [7:0] d, input logic wr);
    bus_addr = a;
    bus_data = d;
    in_mreq  = !(cls == 0 || cls == 2);
    in_iorq  = !(cls == 1 || cls == 2);
    in_wr    = !wr;
  endtask

  task automatic releaseBus();
    in_mreq = 1'b1;
    in_iorq = 1'b1;
    in_wr   = 1'b1;
  endtask

  // One complete bus cycle; cls 0=memory, 1=I/O, 2=both strobes low.
  task automatic applyStimulus(input int cls, input logic [15:0] a, input logic [7:0] d,
                               input logic wr, input int hold);
    clearMon();
    driveBus(cls, a, d, 1'b0);
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      en_hist[i] = {o_en_al, o_en_ah, o_en_d};
      if (i == 3 && wr) in_wr = 1'b0;
    end
    releaseBus();
    repeat (10) @(negedge clk);
  endtask

  task automatic checkCycle(input string tag, input int pulses, input logic [12:0] ea,
                            input logic [7:0] ed, input logic [2:0] eb);
    checkOutput({tag, "_pulses"}, pulse_count, pulses);
    if (pulses != 0) checkOutput({tag, "_we_len"}, last_len, WE_LEN);
    checkOutput({tag, "_addr"}, {19'd0, o_addr}, {19'd0, ea});
    checkOutput({tag, "_data"}, {24'd0, o_data}, {24'd0, ed});
    checkOutput({tag, "_border"}, {29'd0, o_border}, {29'd0, eb});
    checkOutput({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
  endtask

  // Strobe is driven just after negedge 0, so detection takes three edges.
  task automatic checkWindows();
    logic [2:0] exp;
    for (int i = 1; i <= 16; i++) begin
      exp = 3'b111;
      if (i >= 3 && i <= 6)   exp = 3'b011;
      if (i >= 7 && i <= 10)  exp = 3'b101;
      if (i >= 11 && i <= 14) exp = 3'b110;
      checkOutput($sformatf("window_c%0d", i), {29'd0, en_hist[i]}, {29'd0, exp});
    end
  endtask

  task automatic modelCycle(input int cls, input logic [15:0] a, input logic [7:0] d,
                            input logic wr, output int pulses);
    pulses = 0;
    if (wr) begin
      if (cls != 1) begin
        if (a >= 16'h4000 && a <= 16'h5AFF) begin
          pulses   = 1;
          mdl_addr = 13'(a - 16'h4000);
          mdl_data = d;
        end
      end else if (a[0] == 1'b0) begin
        mdl_border = d[2:0];
      end
    end
  endtask

  task automatic waitFor(input string name, input int which, input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (which == 0 && o_we) seen = 1;
      if (which == 1 && !o_en_ah) seen = 1;
    end
    checkOutput(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int pulses, cls, hold;
    logic [15:0] a;
    logic [7:0] d;
    logic wr;

    vecs[0] = '{0, 16'h4123, 8'hA5, 1'b1, 1, 13'h0123, 8'hA5, 3'd7};
    vecs[1] = '{0, 16'h3FFF, 8'h77, 1'b1, 0, 13'h0123, 8'hA5, 3'd7};
    vecs[2] = '{0, 16'h5B00, 8'h88, 1'b1, 0, 13'h0123, 8'hA5, 3'd7};
    vecs[3] = '{0, 16'h5AFF, 8'h3C, 1'b1, 1, 13'h1AFF, 8'h3C, 3'd7};
    vecs[4] = '{0, 16'h4000, 8'h55, 1'b0, 0, 13'h1AFF, 8'h3C, 3'd7};
    vecs[5] = '{1, 16'h00FE, 8'h02, 1'b1, 0, 13'h1AFF, 8'h3C, 3'd2};
    vecs[6] = '{1, 16'h00FF, 8'h05, 1'b1, 0, 13'h1AFF, 8'h3C, 3'd2};
    vecs[7] = '{2, 16'h4000, 8'h99, 1'b1, 1, 13'h0000, 8'h99, 3'd2};
    vecs[8] = '{1, 16'h12FE, 8'hFD, 1'b0, 0, 13'h0000, 8'h99, 3'd2};
    vecs[9] = '{1, 16'h00FE, 8'hFD, 1'b1, 0, 13'h0000, 8'h99, 3'd5};

    repeat (3) @(negedge clk);
    checkOutput("rst_en", {29'd0, o_en_al, o_en_ah, o_en_d}, 32'd7);
    checkOutput("rst_we", {31'd0, o_we}, 32'd0);
    checkOutput("rst_addr", {19'd0, o_addr}, 32'd0);
    checkOutput("rst_data", {24'd0, o_data}, 32'd0);
    checkOutput("rst_border", {29'd0, o_border}, 32'd7);
    checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
    rst_neg = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].cls, vecs[v].addr, vecs[v].data, vecs[v].wr, 40);
      if (v == 0) checkWindows();
      checkCycle($sformatf("vec%0d", v), vecs[v].pulses, vecs[v].e_addr, vecs[v].e_data, vecs[v].e_border);
    end

    // Read cycle: o_busy must drop one edge after synchronized mreq rises.
    clearMon();
    driveBus(0, 16'h4000, 8'h42, 1'b0);
    repeat (25) @(negedge clk);
    #1 releaseBus();
    repeat (2) @(negedge clk);
    checkOutput("read_busy_n2", {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    checkOutput("read_busy_n3", {31'd0, o_busy}, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("read_pulses", pulse_count, 0);

    // Strobe dropped during the A-high lane, then a valid write.
    clearMon();
    driveBus(0, 16'h4000, 8'hEE, 1'b1);
    waitFor("abort_ah_seen", 1, 30);
    releaseBus();
    repeat (10) @(negedge clk);
    checkCycle("abort", 0, 13'h0000, 8'h99, 3'd5);
    applyStimulus(0, 16'h4800, 8'h11, 1'b1, 40);
    checkCycle("after_abort", 1, 13'h0800, 8'h11, 3'd5);

    // Asynchronous reset in the middle of the write pulse.
    clearMon();
    driveBus(0, 16'h4ABC, 8'h5A, 1'b1);
    waitFor("rstw_we_seen", 0, 60);
    #2 rst_neg = 1'b0;
    #1;
    checkOutput("rstw_we", {31'd0, o_we}, 32'd0);
    checkOutput("rstw_en", {29'd0, o_en_al, o_en_ah, o_en_d}, 32'd7);
    checkOutput("rstw_border", {29'd0, o_border}, 32'd7);
    releaseBus();
    repeat (3) @(negedge clk);
    #1 rst_neg = 1'b1;
    clearMon();
    repeat (30) @(negedge clk);
    checkCycle("rstw_after", 0, 13'h0000, 8'h00, 3'd7);

    // Reset mid-cycle with the strobe still held: a fresh cycle after release.
    clearMon();
    driveBus(0, 16'h4321, 8'h77, 1'b1);
    waitFor("rsth_ah_seen", 1, 30);
    #2 rst_neg = 1'b0;
    @(negedge clk);
    #1 rst_neg = 1'b1;
    clearMon();
    repeat (45) @(negedge clk);
    releaseBus();
    repeat (10) @(negedge clk);
    checkCycle("rsth", 1, 13'h0321, 8'h77, 3'd7);

    mdl_addr = 13'h0321;
    mdl_data = 8'h77;
    mdl_border = 3'd7;
    for (int n = 0; n < 40; n++) begin
      cls = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) a = 16'(16'h3FF0 + $urandom_range(0, 16'h1B20));
      else a = 16'($urandom);
      d = 8'($urandom);
      wr = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(30, 45);
      modelCycle(cls, a, d, wr, pulses);
      applyStimulus(cls, a, d, wr, hold);
      checkCycle($sformatf("rnd%0d", n), pulses, mdl_addr, mdl_data, mdl_border);
    end

    checkOutput("invariants", inv_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
